// File: rtl/truth_table_characterizer.sv
// Sweeps all 2^N_IN input vectors into an external gate and assembles its truth-table code.
// Optional compare-against-expected logic is enabled by defining TT_COMPARE_EN.
module truth_table_characterizer #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  localparam int TW           = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TW-1:0]   result
`ifdef TT_COMPARE_EN
  ,
  input  logic [TW-1:0]   expected,
  output logic            match
`endif
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TW - 1);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 1");
    end
    if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
      $error("N_IN must be in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_r;
  logic [N_IN-1:0] idx_r;
  logic [CW-1:0]   cnt_r;
  logic [TW-1:0]   shadow_r;
  logic [TW-1:0]   final_code_s;
`ifdef TT_COMPARE_EN
  logic [TW-1:0]   expected_r;
`endif

  // The last vector maps to bit 0, so the final code is the shadow with the live sample in the LSB.
  always_comb begin
    final_code_s = {shadow_r[TW-1:1], dut_out};
  end

  // Sweep controller; output for vector v lands at bit TW-1-v, i.e. bit index ~v.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      cnt_r      <= '0;
      shadow_r   <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
`ifdef TT_COMPARE_EN
      expected_r <= '0;
      match      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r    <= SETTLE;
            idx_r      <= '0;
            cnt_r      <= '0;
            shadow_r   <= '0;
            stim       <= '0;
            busy       <= 1'b1;
`ifdef TT_COMPARE_EN
            expected_r <= expected;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_r <= IDLE;
            stim    <= '0;
            busy    <= 1'b0;
          end else if (cnt_r == LAST_CNT) begin
            state_r <= SAMPLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        SAMPLE: begin
          if (abort) begin
            state_r <= IDLE;
            stim    <= '0;
            busy    <= 1'b0;
          end else if (idx_r == LAST_IDX) begin
            state_r <= DONE;
            result  <= final_code_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            stim    <= '0;
`ifdef TT_COMPARE_EN
            match   <= (final_code_s == expected_r);
`endif
          end else begin
            shadow_r[~idx_r] <= dut_out;
            idx_r            <= idx_r + N_IN'(1);
            stim             <= idx_r + N_IN'(1);
            cnt_r            <= '0;
            state_r          <= SETTLE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          stim    <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_characterizer.sv
// Directed bench for truth_table_characterizer: table of gate models with hand-derived codes,
// plus abort, reset, extra-start and SETTLE_CYCLES=1 sequences.
module tb_truth_table_characterizer;

  typedef struct {
    int         mode;
    logic [7:0] code;
  } vec_t;

  localparam int M_AND13 = 0;
  localparam int M_ONE   = 1;
  localparam int M_ZERO  = 2;
  localparam int M_IN1   = 3;
  localparam int M_IN3   = 4;
  localparam int M_MAJ   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] stim;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] exp_in = 8'h00;
  logic       match;

  logic       start2 = 1'b0;
  logic [2:0] stim2;
  logic       xor_q;
  logic       busy2;
  logic       done2;
  logic [7:0] result2;
  logic       match2;

  int mode = M_AND13;
  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  // Gate-under-test models selected by mode
  always_comb begin
    case (mode)
      M_AND13: dut_out = stim[2] & stim[0];
      M_ONE:   dut_out = 1'b1;
      M_ZERO:  dut_out = 1'b0;
      M_IN1:   dut_out = stim[2];
      M_IN3:   dut_out = stim[0];
      M_MAJ:   dut_out = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);
      default: dut_out = 1'b0;
    endcase
  end

  // Registered XOR model: output lags stim by one cycle
  always_ff @(posedge clk) xor_q <= ^stim2;

  truth_table_characterizer #(.N_IN(3), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stim(stim),
    .dut_out(dut_out), .busy(busy), .done(done), .result(result)
`ifdef TT_COMPARE_EN
    , .expected(exp_in), .match(match)
`endif
  );

  truth_table_characterizer #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .stim(stim2),
    .dut_out(xor_q), .busy(busy2), .done(done2), .result(result2)
`ifdef TT_COMPARE_EN
    , .expected(8'h00), .match(match2)
`endif
  );

`ifndef TT_COMPARE_EN
  assign match  = 1'b0;
  assign match2 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // One full sweep; expects busy for 40 cycles and a single done at cycle 41
  task automatic sweep(input int md, input logic [7:0] want, input logic [7:0] exp_code,
                       input bit extras, input bit with_abort);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    int stim_bad = 0;
    mode = md;
    exp_in = exp_code;
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (busy) begin
        busy_n++;
        if (stim !== 3'((k - 1) / 5)) stim_bad++;
      end
      if (done) begin
        done_n++;
        done_at = k;
        check("result", 32'(result), 32'(want));
        check("stim_at_done", 32'(stim), 32'd0);
`ifdef TT_COMPARE_EN
        check("match", 32'(match), 32'(exp_code == want));
`endif
      end
      start = (extras && (k == 10 || k == 41)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(busy_n), 32'd40);
    check("done_count", 32'(done_n), 32'd1);
    check("done_cycle", 32'(done_at), 32'd41);
    check("stim_sequence_errs", 32'(stim_bad), 32'd0);
  endtask

  initial begin
    int done_n;
    int busy_n;
    int done_at;

    vecs[0] = '{M_AND13, 8'h05};
    vecs[1] = '{M_ONE,   8'hFF};
    vecs[2] = '{M_ZERO,  8'h00};
    vecs[3] = '{M_IN1,   8'h0F};
    vecs[4] = '{M_IN3,   8'h55};
    vecs[5] = '{M_MAJ,   8'h17};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    rst = 1'b0;

    // Back-to-back table sweeps
    foreach (vecs[i]) sweep(vecs[i].mode, vecs[i].code, vecs[i].code, 1'b0, 1'b0);

    // Extra start pulses while busy and in DONE; wrong expected code
    sweep(M_AND13, 8'h05, 8'h06, 1'b1, 1'b0);
    // start and abort together in IDLE: start wins
    sweep(M_AND13, 8'h05, 8'h05, 1'b0, 1'b1);

    // Abort during vector 3 (cycles 16..20)
    mode = M_ONE;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 17; k++) @(negedge clk);
    check("stim_before_abort", 32'(stim), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_stim", 32'(stim), 32'd0);
    done_n = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) done_n++;
      if (k == 5) abort = 1'b1;
      else abort = 1'b0;
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    check("abort_result_kept", 32'(result), 32'h05);
`ifdef TT_COMPARE_EN
    check("abort_match_kept", 32'(match), 32'd1);
`endif

    // SETTLE_CYCLES=1 with one-cycle-late XOR model
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    busy_n = 0;
    done_at = -1;
    for (int k = 1; k <= 30; k++) begin
      if (busy2) busy_n++;
      if (done2) begin
        done_at = k;
        check("xor_result", 32'(result2), 32'h69);
      end
      @(negedge clk);
    end
    check("xor_busy_cycles", 32'(busy_n), 32'd16);
    check("xor_done_cycle", 32'(done_at), 32'd17);

    // Reset in the middle of a sweep
    mode = M_AND13;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 20; k++) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_stim", 32'(stim), 32'd0);
    check("mid_rst_match", 32'(match), 32'd0);
    done_n = 0;
    for (int k = 0; k < 45; k++) begin
      if (done) done_n++;
      @(negedge clk);
    end
    check("mid_rst_no_done", 32'(done_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_characterizer.md
Name: truth_table_characterizer

Overview:
- Sequential reader for 3-input combinational logic functions: drives all 2^N input vectors into an external gate-under-test and samples its single output after a settle delay.
- Assembles the sampled outputs into the function's truth-table code, using the hex-ID convention the team uses for function names (0x05, ...).
- Sits beside synthesized function blocks in the benchmark harness and reads back the function each one implements.

Parameters:
- N_IN, 3, number of gate inputs; table width TW = 2^N_IN; legal 1..4
- SETTLE_CYCLES, 4, wait cycles after each stimulus change before sampling; legal >= 1, elaboration error otherwise

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a characterization sweep
- abort  input  1  cancels a sweep in progress
- stim  output  N_IN  input vector driven to the gate-under-test; stim[N_IN-1] = in1 (MSB)
- dut_out  input  1  gate-under-test output
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when result is updated
- result  output  TW  captured truth-table code, held until next completed sweep

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; stim=0, busy=0, done=0, result=0, vector index=0, settle counter=0. Reset overrides start and abort in the same cycle.
- Bit ordering: the output for input vector v is stored at result[TW-1-v]. Vector 0 (all inputs 0) lands in the MSB.
- Example: out = in1 & in3 yields result = 8'h05.
- States:
  - IDLE: busy=0. On start=1, go to SETTLE with stim=0, index=0, counter=0, busy=1 from the next cycle.
  - SETTLE: counter increments each cycle. When counter = SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: capture dut_out into shadow[TW-1-index] at this edge.
    - If index = TW-1, go to DONE.
    - Otherwise index+1, stim=index+1, counter=0, go to SETTLE.
  - DONE: result <= shadow (includes the final sample), done=1 for this one cycle, busy=0, stim=0, then IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - busy is high for exactly TW*(SETTLE_CYCLES+1) cycles.
  - done asserts on the cycle after the last SAMPLE.
  - Default parameters: start at cycle 0 -> done at cycle 41.
- Stimulus sequence is stim = 0,1,...,TW-1, ascending and wrap-free. stim changes only on the SAMPLE->SETTLE transition.
- start while busy or in DONE: ignored, no restart.
- abort while busy: next state IDLE, stim=0, busy=0, no done pulse, result unchanged, shadow discarded. abort in IDLE: no effect.
- start and abort asserted together in IDLE: start wins.
- dut_out is assumed synchronous to clk; no internal synchronizer.
- result changes only in DONE or on reset.

Optional Feature:
- Macro: TT_COMPARE_EN.
- When defined:
  - Adds input expected (TW bits) and output match (1 bit).
  - expected is registered on the start-accept edge.
  - In DONE, match <= (shadow == expected_reg), valid alongside done and held until next DONE.
  - Reset clears match to 0; abort leaves match unchanged.
- When undefined: neither port exists and there is no compare logic.

Test Plan:
- AND of in1,in3 model (dut_out = stim[2] & stim[0]), default parameters, start at cycle 0 -> busy high cycles 1..40, done pulse at cycle 41, result = 8'h05, stim returns to 0.
- Constant-1 then constant-0 model, back-to-back sweeps -> result = 8'hFF, then 8'h00; done pulses exactly once per sweep.
- Extra start pulses while busy -> ignored: sweep length unchanged, single done.
- abort during vector 3, after a prior sweep left result = 8'h05 -> busy drops next cycle, no done, result stays 8'h05, stim = 0.
- SETTLE_CYCLES = 1 with a model whose output is registered one cycle behind stim (e.g. XOR of all inputs) -> result = 8'h69, total busy = 16 cycles.
- rst asserted mid-sweep -> next cycle busy=0, result=0, stim=0. With TT_COMPARE_EN and expected = 8'h05 on the AND model -> match = 1; with expected = 8'h06 -> match = 0.
